fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
// - IF stage: owns PC, drives instruction-memory requests, loads the IF/ID pipeline register.
// - Directly upstream of ID and the hazard detection unit; consumes its pc_wen, if_id_wen, if_id_flush.
// - Variable-latency imem (cache) via req/ready; detects HLT and stops fetching.
// PARAMETERS
// - ADDR_W       16       PC / imem address width
// - RESET_PC     16'h0000 PC after reset
// - HALT_OPCODE  4'hF     instr[15:12] value that halts fetch
// PORTS
// - clk            in  1       clock; all state on posedge
// - rst            in  1       asynchronous, active-high reset
// - pc_wen         in  1       from hazard unit; 0 = hold PC
// - if_id_wen      in  1       from hazard unit; 0 = hold IF/ID
// - if_id_flush    in  1       taken branch resolved in ID; redirect and squash
// - br_target      in  ADDR_W  redirect address, valid with if_id_flush
// - imem_req       out 1       fetch request
// - imem_addr      out ADDR_W  fetch address
// - imem_ready     in  1       imem_data valid for imem_addr this cycle
// - imem_data      in  16      instruction
// - if_id_instr    out 16      IF/ID instruction (16'h0000 when bubble)
// - if_id_pc_plus2 out ADDR_W  IF/ID PC+2 of that instruction
// - if_id_valid    out 1       IF/ID holds a real instruction
// - fetch_busy     out 1       1 while in MISS
// - halted         out 1       1 while in HALT
// - miss_cycles    out 16      perf counter (see CONFIGURATION)
// - flush_count    out 16      perf counter (see CONFIGURATION)
// BEHAVIOUR
// - Reset (async): state=RUN, pc=RESET_PC, IF/ID={0,0,valid=0}, halted=0, busy=0, counters=0.
// - States RUN, MISS, HALT. Registers pc, req_addr, discard.
// - RUN: imem_req=1, imem_addr=pc (comb).
//   - ready & !flush & if_id_wen: IF/ID<={data,pc+2,1}; if pc_wen & opcode!=HALT_OPCODE pc<=pc+2.
//   - Accepted instr with opcode==HALT_OPCODE: loaded into IF/ID, pc holds, ->HALT.
//   - ready & if_id_wen=0: IF/ID holds, pc holds; same address refetched next cycle.
//   - !ready: req_addr<=pc, ->MISS; IF/ID<=bubble if if_id_wen.
// - MISS: imem_req=1, imem_addr=req_addr (stable until ready); fetch_busy=1; IF/ID<=bubble if if_id_wen.
//   - ready & !discard & if_id_wen: deliver as in RUN (incl. HALT check), ->RUN.
//   - ready & (discard | !if_id_wen): data dropped, discard<=0, ->RUN (pc refetched).
// - HALT: imem_req=0, halted=1, pc held, IF/ID<=bubble if if_id_wen.
// - if_id_flush (any state, priority over pc_wen/if_id_wen): pc<=br_target, IF/ID<=bubble.
//   - RUN/HALT: ->RUN (flush exits a speculative HALT). Fetched data that cycle ignored.
//   - MISS: stay MISS until ready, discard<=1; request at req_addr completes and is dropped.
// - Hazard unit never asserts if_id_flush with pc_wen=0; if it does, flush wins.
// - PC arithmetic mod 2^ADDR_W; 16'hFFFE+2 wraps to 0.
// - Reset during MISS abandons the request; imem must accept a new address next cycle.
// CONFIGURATION
// - FETCH_PERF_CNT_EN defined: miss_cycles +1 per cycle in MISS; flush_count +1 per
//   if_id_flush cycle; both saturate at 16'hFFFF, cleared by rst.
// - Not defined: counters not built, miss_cycles=flush_count=16'h0000 constantly.
// TESTING
// - rst pulse mid-cycle -> immediately imem_addr=0x0000, if_id_valid=0, halted=0, state RUN.
// - ready=1, pc/if_id_wen=1, data 0x1234,0x2345,0x3456 -> IF/ID pc_plus2 0x2,0x4,0x6, one per cycle.
// - pc_wen=if_id_wen=0 two cycles at pc=0x0006 -> imem_addr stays 0x0006, IF/ID unchanged.
// - ready=0 3 cycles at 0x0008 -> busy=1, addr stable, bubbles; then instr with pc_plus2=0x000A.
// - flush br_target=0x0040 in MISS cycle 2 -> returned data dropped, next addr 0x0040.
// - data 0xF000 at 0x0010 -> halted=1, req=0; flush target 0x0020 -> RUN, addr 0x0020.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// Ports (master = fetch unit, slave = memory / cache):
//   req    fetch request
//   addr   fetch address
//   ready  data valid for addr this cycle
//   data   16-bit instruction word
interface fetch_unit_if #(
    parameter int ADDR_W = 16
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ready;
    logic [15:0]       data;

    modport master (output req, output addr, input ready, input data);
    modport slave  (input req, input addr, output ready, output data);
endinterface

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, issues instruction-memory requests over a
// variable-latency req/ready bus, and loads the IF/ID pipeline register.
// Stops fetching on a HALT opcode; a branch flush redirects and resumes.
//
// Ports:
//   clk, rst            clock / asynchronous active-high reset
//   pc_wen_i            0 = hold PC (hazard unit)
//   if_id_wen_i         0 = hold IF/ID (hazard unit)
//   if_id_flush_i       redirect to br_target_i and squash IF/ID
//   br_target_i         redirect address
//   imem                fetch_unit_if master (req/addr out, ready/data in)
//   if_id_instr_o       IF/ID instruction (0 for a bubble)
//   if_id_pc_plus2_o    IF/ID PC+2 of that instruction
//   if_id_valid_o       IF/ID holds a real instruction
//   fetch_busy_o        waiting on an outstanding miss
//   halted_o            fetch stopped on HALT
//   miss_cycles_o       perf counter: cycles spent in MISS
//   flush_count_o       perf counter: flush cycles
//
// Build option: define FETCH_PERF_CNT_EN to build the saturating perf
// counters; otherwise both counter outputs are tied to zero.
//
// state | meaning
// RUN   | requesting at pc, accepting data when ready
// MISS  | holding req_addr stable until imem returns
// HALT  | HALT opcode fetched; no requests until a flush
module fetch_unit #(
    parameter int              ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [3:0]      HALT_OPCODE = 4'hF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_wen_i,
    input  logic              if_id_wen_i,
    input  logic              if_id_flush_i,
    input  logic [ADDR_W-1:0] br_target_i,
    fetch_unit_if.master      imem,
    output logic [15:0]       if_id_instr_o,
    output logic [ADDR_W-1:0] if_id_pc_plus2_o,
    output logic              if_id_valid_o,
    output logic              fetch_busy_o,
    output logic              halted_o,
    output logic [15:0]       miss_cycles_o,
    output logic [15:0]       flush_count_o
);

    typedef enum logic [1:0] {S_RUN = 2'd0, S_MISS = 2'd1, S_HALT = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              discard_q, discard_d;
    logic [15:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pc2_q, pc2_d;
    logic              valid_q, valid_d;

    logic              is_halt;
    logic              load_instr;
    logic              load_bubble;
    logic [ADDR_W-1:0] load_pc2;

    assign is_halt = (imem.data[15:12] == HALT_OPCODE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_RUN;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            discard_q  <= 1'b0;
            instr_q    <= '0;
            pc2_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            discard_q  <= discard_d;
            instr_q    <= instr_d;
            pc2_q      <= pc2_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        discard_d   = discard_q;
        load_instr  = 1'b0;
        load_bubble = 1'b0;
        load_pc2    = pc_q + ADDR_W'(2);

        if (if_id_flush_i) begin
            pc_d        = br_target_i;
            load_bubble = 1'b1;
            // A miss in flight must still complete; remember to drop its data.
            if (state_q == S_MISS && !imem.ready) begin
                discard_d = 1'b1;
            end else begin
                state_d   = S_RUN;
                discard_d = 1'b0;
            end
        end else begin
            case (state_q)
                S_RUN: begin
                    if (imem.ready) begin
                        if (if_id_wen_i) begin
                            load_instr = 1'b1;
                            if (is_halt)       state_d = S_HALT;
                            else if (pc_wen_i) pc_d    = pc_q + ADDR_W'(2);
                        end
                    end else begin
                        req_addr_d  = pc_q;
                        state_d     = S_MISS;
                        load_bubble = if_id_wen_i;
                    end
                end
                S_MISS: begin
                    load_pc2 = req_addr_q + ADDR_W'(2);
                    if (!imem.ready) begin
                        load_bubble = if_id_wen_i;
                    end else if (!discard_q && if_id_wen_i) begin
                        load_instr = 1'b1;
                        if (is_halt) begin
                            state_d = S_HALT;
                        end else begin
                            state_d = S_RUN;
                            if (pc_wen_i) pc_d = pc_q + ADDR_W'(2);
                        end
                    end else begin
                        // Stale or unconsumable data: drop it and refetch pc.
                        discard_d   = 1'b0;
                        state_d     = S_RUN;
                        load_bubble = if_id_wen_i;
                    end
                end
                S_HALT: begin
                    load_bubble = if_id_wen_i;
                end
                default: begin
                    state_d = S_RUN;
                end
            endcase
        end

        instr_d = instr_q;
        pc2_d   = pc2_q;
        valid_d = valid_q;
        if (load_bubble) begin
            instr_d = '0;
            pc2_d   = '0;
            valid_d = 1'b0;
        end else if (load_instr) begin
            instr_d = imem.data;
            pc2_d   = load_pc2;
            valid_d = 1'b1;
        end
    end

    always_comb begin
        imem.req     = (state_q != S_HALT);
        imem.addr    = (state_q == S_MISS) ? req_addr_q : pc_q;
        fetch_busy_o = (state_q == S_MISS);
        halted_o     = (state_q == S_HALT);
    end

    assign if_id_instr_o    = instr_q;
    assign if_id_pc_plus2_o = pc2_q;
    assign if_id_valid_o    = valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] miss_cnt_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_cnt_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (state_q == S_MISS && miss_cnt_q != 16'hFFFF)
                miss_cnt_q <= miss_cnt_q + 16'd1;
            if (if_id_flush_i && flush_cnt_q != 16'hFFFF)
                flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign miss_cycles_o = miss_cnt_q;
    assign flush_count_o = flush_cnt_q;
`else
    assign miss_cycles_o = 16'h0000;
    assign flush_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_wen;
    logic        if_id_wen;
    logic        if_id_flush;
    logic [15:0] br_target;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc_plus2;
    logic        if_id_valid;
    logic        fetch_busy;
    logic        halted;
    logic [15:0] miss_cycles;
    logic [15:0] flush_count;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(16)) imem ();

    fetch_unit dut (
        .clk              (clk),
        .rst              (rst),
        .pc_wen_i         (pc_wen),
        .if_id_wen_i      (if_id_wen),
        .if_id_flush_i    (if_id_flush),
        .br_target_i      (br_target),
        .imem             (imem),
        .if_id_instr_o    (if_id_instr),
        .if_id_pc_plus2_o (if_id_pc_plus2),
        .if_id_valid_o    (if_id_valid),
        .fetch_busy_o     (fetch_busy),
        .halted_o         (halted),
        .miss_cycles_o    (miss_cycles),
        .flush_count_o    (flush_count)
    );

    // Reference model: what fetch is doing (running / waiting on a miss /
    // halted), which address is outstanding, and what IF/ID should hold.
    bit          m_waiting;
    bit          m_stopped;
    bit          m_drop;
    logic [15:0] m_pc;
    logic [15:0] m_out_addr;
    logic [15:0] m_instr;
    logic [15:0] m_pc2;
    bit          m_valid;
    logic [15:0] m_miss;
    logic [15:0] m_flush;

    function automatic logic [15:0] m_addr();
        return m_waiting ? m_out_addr : m_pc;
    endfunction

    task automatic model_reset();
        m_waiting = 0; m_stopped = 0; m_drop = 0;
        m_pc = 16'h0000; m_out_addr = 16'h0000;
        m_instr = 16'h0000; m_pc2 = 16'h0000; m_valid = 0;
        m_miss = 16'h0000; m_flush = 16'h0000;
    endtask

    task automatic model_bubble();
        m_instr = 16'h0000; m_pc2 = 16'h0000; m_valid = 0;
    endtask

    task automatic model_step(input bit pw, input bit iw, input bit fl,
                              input logic [15:0] br, input bit rdy, input logic [15:0] d);
        logic [15:0] fetched;
        fetched = m_addr();
        if (m_waiting && m_miss != 16'hFFFF) m_miss = m_miss + 16'd1;
        if (fl && m_flush != 16'hFFFF)       m_flush = m_flush + 16'd1;
        if (fl) begin
            model_bubble();
            m_pc = br;
            m_stopped = 0;
            if (m_waiting && !rdy) m_drop = 1;
            else begin m_waiting = 0; m_drop = 0; end
        end else if (m_stopped) begin
            if (iw) model_bubble();
        end else if (!rdy) begin
            if (!m_waiting) begin m_out_addr = m_pc; m_waiting = 1; end
            if (iw) model_bubble();
        end else if (m_waiting && (m_drop || !iw)) begin
            m_waiting = 0; m_drop = 0;
            if (iw) model_bubble();
        end else if (iw) begin
            m_waiting = 0;
            m_instr = d; m_pc2 = fetched + 16'd2; m_valid = 1;
            if (d[15:12] == 4'hF) m_stopped = 1;
            else if (pw) m_pc = m_pc + 16'd2;
        end
    endtask

    // Applies one cycle of stimulus starting at posedge+1; returns at the
    // next posedge+1 with the model advanced.
    task automatic step(input bit pw, input bit iw, input bit fl,
                        input logic [15:0] br, input bit rdy, input logic [15:0] d);
        pc_wen = pw; if_id_wen = iw; if_id_flush = fl; br_target = br;
        imem.ready = rdy; imem.data = d;
        @(posedge clk);
        model_step(pw, iw, fl, br, rdy, d);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        vectors++;
        if ({imem.addr, imem.req, if_id_valid, halted, fetch_busy} !== {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: addr/req/valid/halted/busy got %h/%b/%b/%b/%b want 0000/1/0/0/0",
                     imem.addr, imem.req, if_id_valid, halted, fetch_busy);
        end
        vectors++;
        if ({if_id_instr, if_id_pc_plus2, miss_cycles, flush_count} !== 64'h0) begin
            errors++;
            $display("FAIL reset_regs: instr/pc2/miss/flush got %h/%h/%h/%h want all 0",
                     if_id_instr, if_id_pc_plus2, miss_cycles, flush_count);
        end
        model_reset();
        pc_wen = 1; if_id_wen = 1; if_id_flush = 0; br_target = 0;
        imem.ready = 1; imem.data = 16'h0000;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        logic [15:0] words [3];
        words[0] = 16'h1234; words[1] = 16'h2345; words[2] = 16'h3456;
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 16'h0, 1, words[i]);
            vectors++;
            if ({if_id_instr, if_id_pc_plus2, if_id_valid} !== {words[i], 16'(2 * (i + 1)), 1'b1}) begin
                errors++;
                $display("FAIL seq_%0d: instr/pc2/valid got %h/%h/%b want %h/%h/1",
                         i, if_id_instr, if_id_pc_plus2, if_id_valid, words[i], 16'(2 * (i + 1)));
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 16'h0, 1, 16'h7777);
            vectors++;
            if ({imem.addr, if_id_instr, if_id_pc_plus2, if_id_valid} !== {16'h0006, 16'h3456, 16'h0006, 1'b1}) begin
                errors++;
                $display("FAIL stall_%0d: addr/instr/pc2/valid got %h/%h/%h/%b want 0006/3456/0006/1",
                         i, imem.addr, if_id_instr, if_id_pc_plus2, if_id_valid);
            end
        end
        step(1, 1, 0, 16'h0, 1, 16'h4567);
        vectors++;
        if ({imem.addr, if_id_pc_plus2} !== {16'h0008, 16'h0008}) begin
            errors++;
            $display("FAIL stall_resume: addr/pc2 got %h/%h want 0008/0008", imem.addr, if_id_pc_plus2);
        end
    endtask

    task automatic test_miss();
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 16'h0, 0, 16'hDEAD);
            vectors++;
            if ({fetch_busy, imem.addr, imem.req, if_id_valid, if_id_instr} !== {1'b1, 16'h0008, 1'b1, 1'b0, 16'h0000}) begin
                errors++;
                $display("FAIL miss_%0d: busy/addr/req/valid/instr got %b/%h/%b/%b/%h want 1/0008/1/0/0000",
                         i, fetch_busy, imem.addr, imem.req, if_id_valid, if_id_instr);
            end
        end
        step(1, 1, 0, 16'h0, 1, 16'h5678);
        vectors++;
        if ({fetch_busy, if_id_instr, if_id_pc_plus2, if_id_valid, imem.addr} !== {1'b0, 16'h5678, 16'h000A, 1'b1, 16'h000A}) begin
            errors++;
            $display("FAIL miss_done: busy/instr/pc2/valid/addr got %b/%h/%h/%b/%h want 0/5678/000a/1/000a",
                     fetch_busy, if_id_instr, if_id_pc_plus2, if_id_valid, imem.addr);
        end
    endtask

    task automatic test_flush_in_miss();
        step(1, 1, 0, 16'h0, 0, 16'h0);
        step(1, 1, 0, 16'h0, 0, 16'h0);
        step(1, 1, 1, 16'h0040, 0, 16'h0);
        vectors++;
        if ({fetch_busy, imem.addr} !== {1'b1, 16'h000A}) begin
            errors++;
            $display("FAIL flush_miss_hold: busy/addr got %b/%h want 1/000a", fetch_busy, imem.addr);
        end
        step(1, 1, 0, 16'h0, 1, 16'h1111);
        vectors++;
        if ({if_id_valid, if_id_instr, fetch_busy, imem.addr} !== {1'b0, 16'h0000, 1'b0, 16'h0040}) begin
            errors++;
            $display("FAIL flush_miss_drop: valid/instr/busy/addr got %b/%h/%b/%h want 0/0000/0/0040",
                     if_id_valid, if_id_instr, fetch_busy, imem.addr);
        end
    endtask

    task automatic test_halt();
        step(1, 1, 1, 16'h0010, 1, 16'h2222);
        step(1, 1, 0, 16'h0, 1, 16'hF000);
        vectors++;
        if ({halted, imem.req, if_id_instr, if_id_valid, if_id_pc_plus2} !== {1'b1, 1'b0, 16'hF000, 1'b1, 16'h0012}) begin
            errors++;
            $display("FAIL halt_enter: halted/req/instr/valid/pc2 got %b/%b/%h/%b/%h want 1/0/f000/1/0012",
                     halted, imem.req, if_id_instr, if_id_valid, if_id_pc_plus2);
        end
        step(1, 1, 0, 16'h0, 1, 16'h3333);
        vectors++;
        if ({halted, imem.req, if_id_valid} !== {1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL halt_stay: halted/req/valid got %b/%b/%b want 1/0/0", halted, imem.req, if_id_valid);
        end
        step(1, 1, 1, 16'h0020, 1, 16'h4444);
        vectors++;
        if ({halted, imem.req, imem.addr} !== {1'b0, 1'b1, 16'h0020}) begin
            errors++;
            $display("FAIL halt_exit: halted/req/addr got %b/%b/%h want 0/1/0020", halted, imem.req, imem.addr);
        end
    endtask

    task automatic test_wrap();
        step(1, 1, 1, 16'hFFFE, 1, 16'h0);
        step(1, 1, 0, 16'h0, 1, 16'h0ABC);
        vectors++;
        if ({if_id_pc_plus2, imem.addr, if_id_instr} !== {16'h0000, 16'h0000, 16'h0ABC}) begin
            errors++;
            $display("FAIL wrap: pc2/addr/instr got %h/%h/%h want 0000/0000/0abc",
                     if_id_pc_plus2, imem.addr, if_id_instr);
        end
    endtask

    task automatic test_random();
        bit          pw, iw, fl, rdy;
        logic [15:0] br, d;
        for (int i = 0; i < 600; i++) begin
            fl  = ($urandom_range(0, 11) == 0);
            pw  = fl ? 1'b1 : ($urandom_range(0, 3) != 0);
            iw  = ($urandom_range(0, 4) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            br  = 16'($urandom) & 16'hFFFE;
            d   = 16'($urandom);
            pc_wen = pw; if_id_wen = iw; if_id_flush = fl; br_target = br;
            imem.ready = rdy; imem.data = d;
            #1;
            vectors++;
            if ({imem.req, imem.addr, fetch_busy, halted} !== {!m_stopped, m_addr(), m_waiting, m_stopped}) begin
                errors++;
                $display("FAIL rand_fetch_%0d: req/addr/busy/halted got %b/%h/%b/%b want %b/%h/%b/%b",
                         i, imem.req, imem.addr, fetch_busy, halted, !m_stopped, m_addr(), m_waiting, m_stopped);
            end
            @(posedge clk);
            model_step(pw, iw, fl, br, rdy, d);
            #1;
            vectors++;
            if ({if_id_instr, if_id_pc_plus2, if_id_valid} !== {m_instr, m_pc2, m_valid}) begin
                errors++;
                $display("FAIL rand_ifid_%0d: instr/pc2/valid got %h/%h/%b want %h/%h/%b",
                         i, if_id_instr, if_id_pc_plus2, if_id_valid, m_instr, m_pc2, m_valid);
            end
        end
        vectors++;
`ifdef FETCH_PERF_CNT_EN
        if ({miss_cycles, flush_count} !== {m_miss, m_flush}) begin
            errors++;
            $display("FAIL perf_cnt: miss/flush got %0d/%0d want %0d/%0d", miss_cycles, flush_count, m_miss, m_flush);
        end
`else
        if ({miss_cycles, flush_count} !== 32'h0) begin
            errors++;
            $display("FAIL perf_cnt_off: miss/flush got %h/%h want 0000/0000", miss_cycles, flush_count);
        end
`endif
    endtask

    task automatic test_reset_in_miss();
        step(1, 1, 1, 16'h0100, 1, 16'h0);
        step(1, 1, 0, 16'h0, 0, 16'h0);
        vectors++;
        if ({fetch_busy, imem.addr} !== {1'b1, 16'h0100}) begin
            errors++;
            $display("FAIL pre_reset_miss: busy/addr got %b/%h want 1/0100", fetch_busy, imem.addr);
        end
        test_reset();
        step(1, 1, 0, 16'h0, 1, 16'h0777);
        vectors++;
        if ({if_id_instr, if_id_pc_plus2, if_id_valid, imem.addr} !== {16'h0777, 16'h0002, 1'b1, 16'h0002}) begin
            errors++;
            $display("FAIL post_reset_fetch: instr/pc2/valid/addr got %h/%h/%b/%h want 0777/0002/1/0002",
                     if_id_instr, if_id_pc_plus2, if_id_valid, imem.addr);
        end
    endtask

    initial begin
        rst = 1'b1;
        pc_wen = 1; if_id_wen = 1; if_id_flush = 0; br_target = 16'h0;
        imem.ready = 1; imem.data = 16'h0;
        model_reset();
        test_reset();
        test_sequential();
        test_stall();
        test_miss();
        test_flush_in_miss();
        test_halt();
        test_wrap();
        test_reset_in_miss();
        test_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
